// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and the load-use stall out.
// hold/flush are the control inputs that the pipeline control drives into the stage.
interface id_ex_pipe_reg_if #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 4
);
   logic               hold;
   logic               flush;
   logic               id_valid;
   logic [4:0]         id_rs1_addr;
   logic [4:0]         id_rs2_addr;
   logic               id_uses_rs1;
   logic               id_uses_rs2;
   logic [4:0]         id_rd_addr;
   logic               id_regwrite;
   logic               id_memread;
   logic               id_memwrite;
   logic               id_mem_to_reg;
   logic               id_alu_src;
   logic [ALUOP_W-1:0] id_alu_op;
   logic [XLEN-1:0]    id_rs1_data;
   logic [XLEN-1:0]    id_rs2_data;
   logic [XLEN-1:0]    id_imm;
   logic [XLEN-1:0]    id_pc;

   logic               id_ex_valid;
   logic [4:0]         id_ex_rs1_addr;
   logic [4:0]         id_ex_rs2_addr;
   logic               id_ex_uses_rs1;
   logic               id_ex_uses_rs2;
   logic [4:0]         id_ex_rd_addr;
   logic               id_ex_regwrite;
   logic               id_ex_memread;
   logic               id_ex_memwrite;
   logic               id_ex_mem_to_reg;
   logic               id_ex_alu_src;
   logic [ALUOP_W-1:0] id_ex_alu_op;
   logic [XLEN-1:0]    id_ex_rs1_data;
   logic [XLEN-1:0]    id_ex_rs2_data;
   logic [XLEN-1:0]    id_ex_imm;
   logic [XLEN-1:0]    id_ex_pc;
   logic               load_use_stall;

   modport master (
      output hold, flush, id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
             id_rd_addr, id_regwrite, id_memread, id_memwrite, id_mem_to_reg, id_alu_src,
             id_alu_op, id_rs1_data, id_rs2_data, id_imm, id_pc,
      input  id_ex_valid, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_uses_rs1, id_ex_uses_rs2,
             id_ex_rd_addr, id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_mem_to_reg,
             id_ex_alu_src, id_ex_alu_op, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc,
             load_use_stall
   );

   modport slave (
      input  hold, flush, id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
             id_rd_addr, id_regwrite, id_memread, id_memwrite, id_mem_to_reg, id_alu_src,
             id_alu_op, id_rs1_data, id_rs2_data, id_imm, id_pc,
      output id_ex_valid, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_uses_rs1, id_ex_uses_rs2,
             id_ex_rd_addr, id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_mem_to_reg,
             id_ex_alu_src, id_ex_alu_op, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc,
             load_use_stall
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and global hold.
// Optional HAZARD_CNT_EN adds saturating bubble_cnt/flush_cnt event counters.
module id_ex_pipe_reg #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 4
) (
   input logic clk,
   input logic rst,
   id_ex_pipe_reg_if.slave bus
`ifdef HAZARD_CNT_EN
   ,
   output logic [31:0] bubble_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef struct packed {
      logic               valid;
      logic [4:0]         rs1_addr;
      logic [4:0]         rs2_addr;
      logic               uses_rs1;
      logic               uses_rs2;
      logic [4:0]         rd_addr;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               mem_to_reg;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
      logic [XLEN-1:0]    rs1_data;
      logic [XLEN-1:0]    rs2_data;
      logic [XLEN-1:0]    imm;
      logic [XLEN-1:0]    pc;
   } ex_t;

   ex_t  cur;
   ex_t  nxt;
   ex_t  id_fields;
   logic rs_match;
   logic lus;

   assign id_fields = '{
      valid:      bus.id_valid,
      rs1_addr:   bus.id_rs1_addr,
      rs2_addr:   bus.id_rs2_addr,
      uses_rs1:   bus.id_uses_rs1,
      uses_rs2:   bus.id_uses_rs2,
      rd_addr:    bus.id_rd_addr,
      regwrite:   bus.id_regwrite,
      memread:    bus.id_memread,
      memwrite:   bus.id_memwrite,
      mem_to_reg: bus.id_mem_to_reg,
      alu_src:    bus.id_alu_src,
      alu_op:     bus.id_alu_op,
      rs1_data:   bus.id_rs1_data,
      rs2_data:   bus.id_rs2_data,
      imm:        bus.id_imm,
      pc:         bus.id_pc
   };

   // id_valid qualifies the ID fields; load_use_stall is the back-pressure to PC/IF/ID,
   // asserted only when this edge will actually be consumed (no hold, no flush).
   assign rs_match = (bus.id_uses_rs1 && (bus.id_rs1_addr == cur.rd_addr)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2_addr == cur.rd_addr));
   assign lus = !bus.hold && !bus.flush && bus.id_valid && cur.valid && cur.memread &&
                (cur.rd_addr != 5'd0) && rs_match;
   assign bus.load_use_stall = lus;

   always_comb begin
      nxt = '0;
      if (!bus.flush && !lus && bus.id_valid) begin
         nxt = id_fields;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= '0;
      end else if (!bus.hold) begin
         cur <= nxt;
      end
   end

`ifdef HAZARD_CNT_EN
   // Counters only write on an increment so they stay put while saturated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!bus.hold) begin
         if (bus.flush && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
         if (lus && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

   assign bus.id_ex_valid      = cur.valid;
   assign bus.id_ex_rs1_addr   = cur.rs1_addr;
   assign bus.id_ex_rs2_addr   = cur.rs2_addr;
   assign bus.id_ex_uses_rs1   = cur.uses_rs1;
   assign bus.id_ex_uses_rs2   = cur.uses_rs2;
   assign bus.id_ex_rd_addr    = cur.rd_addr;
   assign bus.id_ex_regwrite   = cur.regwrite;
   assign bus.id_ex_memread    = cur.memread;
   assign bus.id_ex_memwrite   = cur.memwrite;
   assign bus.id_ex_mem_to_reg = cur.mem_to_reg;
   assign bus.id_ex_alu_src    = cur.alu_src;
   assign bus.id_ex_alu_op     = cur.alu_op;
   assign bus.id_ex_rs1_data   = cur.rs1_data;
   assign bus.id_ex_rs2_data   = cur.rs2_data;
   assign bus.id_ex_imm        = cur.imm;
   assign bus.id_ex_pc         = cur.pc;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed + randomized bench for id_ex_pipe_reg against an instruction-level model.
// Build with HAZARD_CNT_EN to also exercise the hazard counters.
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        mem_to_reg;
      logic        alu_src;
      logic [3:0]  alu_op;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [31:0] pc;
   } ins_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   ins_t m;
   logic [31:0] exp_bub = '0;
   logic [31:0] exp_fl  = '0;

   id_ex_pipe_reg_if bus ();

`ifdef HAZARD_CNT_EN
   logic [31:0] bubble_cnt;
   logic [31:0] flush_cnt;
   id_ex_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));
`else
   id_ex_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t got();
      ins_t g;
      g = '{bus.id_ex_valid, bus.id_ex_rs1_addr, bus.id_ex_rs2_addr, bus.id_ex_uses_rs1,
            bus.id_ex_uses_rs2, bus.id_ex_rd_addr, bus.id_ex_regwrite, bus.id_ex_memread,
            bus.id_ex_memwrite, bus.id_ex_mem_to_reg, bus.id_ex_alu_src, bus.id_ex_alu_op,
            bus.id_ex_rs1_data, bus.id_ex_rs2_data, bus.id_ex_imm, bus.id_ex_pc};
      return g;
   endfunction

   function automatic ins_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic mw);
      ins_t i;
      i.valid = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.rd = rd;
      i.memread = mr; i.memwrite = mw; i.mem_to_reg = mr; i.regwrite = !mw;
      i.alu_src = mr | mw; i.alu_op = 4'($urandom_range(0, 15));
      i.rs1_data = $urandom; i.rs2_data = $urandom; i.imm = $urandom; i.pc = $urandom;
      return i;
   endfunction

   // A load in EX whose nonzero rd is read by the valid ID instruction must stall.
   function automatic logic exp_stall(input ins_t i, input logic h, input logic f);
      if (h || f || !i.valid || !m.valid || !m.memread || m.rd == 5'd0) return 1'b0;
      return (i.u1 && i.rs1 == m.rd) || (i.u2 && i.rs2 == m.rd);
   endfunction

   task automatic apply(input ins_t i, input logic h, input logic f);
      bus.hold = h; bus.flush = f; bus.id_valid = i.valid;
      bus.id_rs1_addr = i.rs1; bus.id_rs2_addr = i.rs2;
      bus.id_uses_rs1 = i.u1; bus.id_uses_rs2 = i.u2; bus.id_rd_addr = i.rd;
      bus.id_regwrite = i.regwrite; bus.id_memread = i.memread; bus.id_memwrite = i.memwrite;
      bus.id_mem_to_reg = i.mem_to_reg; bus.id_alu_src = i.alu_src; bus.id_alu_op = i.alu_op;
      bus.id_rs1_data = i.rs1_data; bus.id_rs2_data = i.rs2_data;
      bus.id_imm = i.imm; bus.id_pc = i.pc;
   endtask

   task automatic check_cnt(input string tag);
`ifdef HAZARD_CNT_EN
      chk({tag, "_bubble_cnt"}, 160'(bubble_cnt), 160'(exp_bub));
      chk({tag, "_flush_cnt"}, 160'(flush_cnt), 160'(exp_fl));
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   // One cycle: drive at negedge, check stall, then check EX contents after the edge.
   task automatic step(input ins_t i, input logic h, input logic f, input string tag);
      logic s;
      @(negedge clk);
      apply(i, h, f);
      #1;
      s = exp_stall(i, h, f);
      chk({tag, "_stall"}, 160'(bus.load_use_stall), 160'(s));
      @(posedge clk);
      if (!h) begin
         if (f && exp_fl != 32'hFFFF_FFFF) exp_fl++;
         if (s && exp_bub != 32'hFFFF_FFFF) exp_bub++;
         m = (f || s || !i.valid) ? '0 : i;
      end
      #1;
      chk({tag, "_ex"}, 160'(got()), 160'(m));
      check_cnt(tag);
   endtask

   initial begin
      ins_t a;
      ins_t b;
      m = '0;
      apply(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
      #2;
      chk("reset_ex", 160'(got()), 160'(m));
      chk("reset_stall", 160'(bus.load_use_stall), 160'd0);
      check_cnt("reset");
      @(negedge clk);
      rst = 1'b0;

      // Load then dependent add: one bubble, then the add enters.
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x5");
      a = mk(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      step(a, 1'b0, 1'b0, "add_stalled");
      step(a, 1'b0, 1'b0, "add_enters");
      chk("add_rs1", 160'(bus.id_ex_rs1_addr), 160'd5);

      // Load to x0 never stalls; unused rs2 match never stalls.
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x0");
      step(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0), 1'b0, 1'b0, "dep_x0");
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x6");
      step(mk(1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0), 1'b0, 1'b0, "rs2_unused");

      // Flush wins over a pending hazard.
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x7");
      step(mk(1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0), 1'b0, 1'b1, "flush_hazard");

      // Hold freezes everything, even with flush and a hazard pending.
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x8");
      a = mk(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
      step(a, 1'b1, 1'b1, "hold_flush");
      step(a, 1'b1, 1'b0, "hold_only");
      step(a, 1'b0, 1'b0, "after_hold");
      step(a, 1'b0, 1'b0, "after_hold_cap");

      // Store data via rs2 still stalls; back-to-back loads stall independently.
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x9");
      step(mk(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, 1'b0, "sw_dep");
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x10");
      b = mk(1'b1, 5'd10, 5'd2, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
      step(b, 1'b0, 1'b0, "lw_x11_stall");
      step(b, 1'b0, 1'b0, "lw_x11_cap");
      step(mk(1'b1, 5'd11, 5'd2, 1'b1, 1'b0, 5'd12, 1'b0, 1'b0), 1'b0, 1'b0, "add_x11_stall");

      // Asynchronous reset between edges.
      step(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0), 1'b0, 1'b0, "lw_x13");
      @(negedge clk);
      apply(mk(1'b1, 5'd13, 5'd2, 1'b1, 1'b0, 5'd14, 1'b0, 1'b0), 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      m = '0; exp_bub = '0; exp_fl = '0;
      chk("async_rst_ex", 160'(got()), 160'(m));
      chk("async_rst_stall", 160'(bus.load_use_stall), 160'd0);
      check_cnt("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic over a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         a = mk(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
         step(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), "rand");
      end

`ifdef HAZARD_CNT_EN
      // Saturation: preset bubble_cnt near the top, then add three load-use bubbles.
      step(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, "sat_idle");
      @(negedge clk);
      force dut.bubble_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.bubble_cnt;
      exp_bub = 32'hFFFF_FFFE;
      for (int n = 0; n < 3; n++) begin
         step(mk(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0, "sat_lw");
         step(mk(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0), 1'b0, 1'b0, "sat_dep");
      end
      chk("sat_final", 160'(bubble_cnt), 160'(32'hFFFF_FFFF));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
